// File: rtl/micro_seq_pkg.sv
// Shared types and microword field layout for the micro_sequencer.
package micro_seq_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_SEQ  = 4'd0,
    OP_JMP  = 4'd1,
    OP_BRT  = 4'd2,
    OP_BRF  = 4'd3,
    OP_CALL = 4'd4,
    OP_RET  = 4'd5,
    OP_LDC  = 4'd6,
    OP_DJNZ = 4'd7,
    OP_HALT = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    FLT_NONE      = 2'd0,
    FLT_OVERFLOW  = 2'd1,
    FLT_UNDERFLOW = 2'd2,
    FLT_ILLEGAL   = 2'd3
  } fault_t;

  // Microword layout, MSB to LSB: ctrl | next_addr | cond_sel | op
  function automatic int unsigned csel_lsb();
    return OP_W;
  endfunction

  function automatic int unsigned next_lsb(input int unsigned csel_w);
    return OP_W + csel_w;
  endfunction

  function automatic int unsigned ctrl_lsb(input int unsigned addr_w, input int unsigned csel_w);
    return OP_W + csel_w + addr_w;
  endfunction

  function automatic int unsigned uword_w(input int unsigned cw_w, input int unsigned addr_w,
                                          input int unsigned csel_w);
    return cw_w + addr_w + csel_w + OP_W;
  endfunction

endpackage

// File: rtl/micro_seq_stack.sv
// Return-address LIFO for CALL/RET; push when full and pop when empty are ignored.
module micro_seq_stack #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic [DATA_W-1:0] top_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] entry_q [DEPTH];

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign top_o   = entry_q[PTR_W'(count_q - CNT_W'(1))];

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (push_i && !full_o) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Entries need no reset: only slots below count_q are ever read meaningfully.
  always_ff @(posedge clock) begin
    if (push_i && !full_o) begin
      entry_q[PTR_W'(count_q)] <= push_data_i;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Loadable microprogram sequencer: writable store, branch/call/loop control, halt and fault.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter  int unsigned CW_W        = 39,
  parameter  int unsigned ADDR_W      = 5,
  parameter  int unsigned NCOND       = 8,
  parameter  int unsigned STACK_DEPTH = 4,
  localparam int unsigned CSEL_W      = $clog2(NCOND),
  localparam int unsigned UW          = uword_w(CW_W, ADDR_W, CSEL_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              step_en,
  input  logic [NCOND-1:0]  cond_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [UW-1:0]     wr_data,
  output logic [CW_W-1:0]   ctrl_out,
  output logic              ctrl_valid,
  output logic [ADDR_W-1:0] upc_out,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic              wr_err
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned CSEL_LSB = csel_lsb();
  localparam int unsigned NEXT_LSB = next_lsb(CSEL_W);
  localparam int unsigned CTRL_LSB = ctrl_lsb(ADDR_W, CSEL_W);
  localparam int unsigned CPAD     = 2 ** CSEL_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] lcnt_q, lcnt_d;
  fault_t            fault_code_q, fault_code_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;

  logic [UW-1:0]     mem_q [DEPTH];
  logic [UW-1:0]     uword;
  logic [OP_W-1:0]   op_raw;
  logic [CSEL_W-1:0] csel;
  logic [ADDR_W-1:0] next_addr;
  logic [CW_W-1:0]   ctrl_field;
  logic [ADDR_W-1:0] upc_inc;
  logic [CPAD-1:0]   cond_pad;
  logic              cond_bit;

  logic              stk_clear, stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top;

  // Store survives reset; writes are blocked while a program runs.
  always_ff @(posedge clock) begin
    if (wr_en && (state_q != ST_RUN)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign uword      = mem_q[upc_q];
  assign op_raw     = uword[OP_W-1:0];
  assign csel       = uword[CSEL_LSB +: CSEL_W];
  assign next_addr  = uword[NEXT_LSB +: ADDR_W];
  assign ctrl_field = uword[CTRL_LSB +: CW_W];
  assign upc_inc    = upc_q + ADDR_W'(1);
  // Zero padding makes selectors beyond NCOND read as a false condition.
  assign cond_pad   = CPAD'(cond_in);
  assign cond_bit   = cond_pad[csel];

  micro_seq_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_stack (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (stk_clear),
    .push_i      (stk_push),
    .pop_i       (stk_pop),
    .push_data_i (upc_inc),
    .top_o       (stk_top),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      upc_q        <= '0;
      lcnt_q       <= '0;
      fault_code_q <= FLT_NONE;
      done_q       <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      upc_q        <= upc_d;
      lcnt_q       <= lcnt_d;
      fault_code_q <= fault_code_d;
      done_q       <= done_d;
      wr_err_q     <= wr_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    upc_d        = upc_q;
    lcnt_d       = lcnt_q;
    fault_code_d = fault_code_q;
    done_d       = 1'b0;
    wr_err_d     = wr_en && (state_q == ST_RUN);
    stk_clear    = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    ctrl_valid   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (step_en) begin
          ctrl_valid = 1'b1;
          case (op_raw)
            OP_SEQ: upc_d = upc_inc;
            OP_JMP: upc_d = next_addr;
            OP_BRT: upc_d = cond_bit ? next_addr : upc_inc;
            OP_BRF: upc_d = cond_bit ? upc_inc : next_addr;
            OP_CALL: begin
              if (stk_full) begin
                state_d      = ST_FAULT;
                fault_code_d = FLT_OVERFLOW;
              end else begin
                stk_push = 1'b1;
                upc_d    = next_addr;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                state_d      = ST_FAULT;
                fault_code_d = FLT_UNDERFLOW;
              end else begin
                stk_pop = 1'b1;
                upc_d   = stk_top;
              end
            end
            OP_LDC: begin
              lcnt_d = next_addr;
              upc_d  = upc_inc;
            end
            OP_DJNZ: begin
              if (lcnt_q != '0) begin
                lcnt_d = lcnt_q - ADDR_W'(1);
                upc_d  = next_addr;
              end else begin
                upc_d = upc_inc;
              end
            end
            OP_HALT: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
            default: begin
              ctrl_valid   = 1'b0;
              state_d      = ST_FAULT;
              fault_code_d = FLT_ILLEGAL;
            end
          endcase
        end
      end
      default: begin
        if (start) begin
          state_d      = ST_RUN;
          upc_d        = start_addr;
          stk_clear    = 1'b1;
          fault_code_d = FLT_NONE;
        end
      end
    endcase

    ctrl_out = ctrl_valid ? ctrl_field : '0;
  end

  assign upc_out    = upc_q;
  assign busy       = (state_q == ST_RUN);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign done       = done_q;
  assign wr_err     = wr_err_q;

endmodule
